// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, run-time parity (none/even/odd) and 1/2 stop bits.
// Frames are sent LSB first; the line output is registered and idles high.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Rst_L,
  input  logic                         i_Tx_DV,
  input  logic [DATA_BITS-1:0]         i_Tx_Byte,
  input  logic [1:0]                   i_Parity_Mode,
  input  logic                         i_Two_Stop,
  output logic                         o_Tx_Ready,
  output logic                         o_Tx_Active,
  output logic                         o_Tx_Serial,
  output logic                         o_Tx_Done,
  output logic                         o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_Fifo_Count
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
  } state_t;

  state_t               r_State;
  state_t               w_Next_State;
  logic [CNT_W-1:0]     r_Clk_Cnt;
  logic [BIT_W-1:0]     r_Bit_Idx;
  logic [BIT_W-1:0]     w_Next_Bit_Idx;
  logic                 r_Stop_Idx;
  logic                 w_Next_Stop_Idx;
  logic [DATA_BITS-1:0] r_Data;
  logic [1:0]           r_Par_Mode;
  logic                 r_Two_Stop;
  logic                 r_Tx_Serial;
  logic                 w_Next_Serial;

  logic [DATA_BITS-1:0] r_Mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_Wr_Ptr;
  logic [PTR_W-1:0]     r_Rd_Ptr;
  logic [FCNT_W-1:0]    r_Count;

  logic w_Full;
  logic w_Empty;
  logic w_Wr;
  logic w_Pop;
  logic w_Bit_End;
  logic w_Has_Par;
  logic w_Parity;

  assign w_Full    = (r_Count == FIFO_FULL);
  assign w_Empty   = (r_Count == '0);
  assign w_Wr      = i_Tx_DV && !w_Full;
  assign w_Bit_End = (r_Clk_Cnt == CNT_MAX);
  assign w_Has_Par = (r_Par_Mode == 2'b01) || (r_Par_Mode == 2'b10);
  assign w_Parity  = (^r_Data) ^ (r_Par_Mode == 2'b10);

  assign o_Tx_Ready   = !w_Full;
  assign o_Overflow   = i_Tx_DV && w_Full;
  assign o_Fifo_Count = r_Count;
  assign o_Tx_Serial  = r_Tx_Serial;

  // FIFO storage and the frame data register carry no reset
  always_ff @(posedge i_Clock) begin
    if (w_Wr) r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
    if (w_Pop) r_Data <= r_Mem[r_Rd_Ptr];
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Wr) r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
      if (w_Pop) r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
      if (w_Wr && !w_Pop) r_Count <= r_Count + FCNT_W'(1);
      else if (!w_Wr && w_Pop) r_Count <= r_Count - FCNT_W'(1);
    end
  end

  // State register plus the per-frame counters and the registered line
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= S_IDLE;
      r_Clk_Cnt   <= '0;
      r_Bit_Idx   <= '0;
      r_Stop_Idx  <= 1'b0;
      r_Par_Mode  <= 2'b00;
      r_Two_Stop  <= 1'b0;
      r_Tx_Serial <= 1'b1;
    end else begin
      r_State     <= w_Next_State;
      r_Bit_Idx   <= w_Next_Bit_Idx;
      r_Stop_Idx  <= w_Next_Stop_Idx;
      r_Tx_Serial <= w_Next_Serial;
      if (w_Pop) begin
        r_Par_Mode <= i_Parity_Mode;
        r_Two_Stop <= i_Two_Stop;
      end
      if (o_Tx_Active) r_Clk_Cnt <= w_Bit_End ? '0 : r_Clk_Cnt + CNT_W'(1);
      else r_Clk_Cnt <= '0;
    end
  end

  always_comb begin
    w_Next_State    = r_State;
    w_Next_Bit_Idx  = r_Bit_Idx;
    w_Next_Stop_Idx = r_Stop_Idx;
    case (r_State)
      S_IDLE: begin
        w_Next_Bit_Idx  = '0;
        w_Next_Stop_Idx = 1'b0;
        if (!w_Empty) w_Next_State = S_START;
      end
      S_START:  if (w_Bit_End) w_Next_State = S_DATA;
      S_DATA: begin
        if (w_Bit_End) begin
          if (r_Bit_Idx == BIT_LAST) w_Next_State = w_Has_Par ? S_PARITY : S_STOP;
          else w_Next_Bit_Idx = r_Bit_Idx + BIT_W'(1);
        end
      end
      S_PARITY: if (w_Bit_End) w_Next_State = S_STOP;
      S_STOP: begin
        if (w_Bit_End) begin
          if (r_Two_Stop && !r_Stop_Idx) w_Next_Stop_Idx = 1'b1;
          else w_Next_State = S_CLEANUP;
        end
      end
      S_CLEANUP: w_Next_State = S_IDLE;
      default:   w_Next_State = S_IDLE;
    endcase
  end

  // The line value is chosen for the state being entered so it changes on the same edge
  always_comb begin
    w_Pop         = (r_State == S_IDLE) && !w_Empty;
    o_Tx_Active   = (r_State == S_START) || (r_State == S_DATA) ||
                    (r_State == S_PARITY) || (r_State == S_STOP);
    o_Tx_Done     = (r_State == S_CLEANUP);
    w_Next_Serial = 1'b1;
    case (w_Next_State)
      S_START:  w_Next_Serial = 1'b0;
      S_DATA:   w_Next_Serial = r_Data[w_Next_Bit_Idx];
      S_PARITY: w_Next_Serial = w_Parity;
      default:  w_Next_Serial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8-bit and a 5-bit instance, expected frames queued on write
// and compared cycle by cycle on the line by a monitor per instance.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] pm;
  logic       ts;
  logic       dv8, dv5;
  logic [7:0] b8;
  logic [4:0] b5;
  logic       ready8, active8, ser8, done8, ovf8;
  logic       ready5, active5, ser5, done5, ovf5;
  logic [2:0] cnt8, cnt5;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv8), .i_Tx_Byte(b8),
    .i_Parity_Mode(pm), .i_Two_Stop(ts), .o_Tx_Ready(ready8), .o_Tx_Active(active8),
    .o_Tx_Serial(ser8), .o_Tx_Done(done8), .o_Overflow(ovf8), .o_Fifo_Count(cnt8));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv5), .i_Tx_Byte(b5),
    .i_Parity_Mode(pm), .i_Two_Stop(ts), .o_Tx_Ready(ready5), .o_Tx_Active(active5),
    .o_Tx_Serial(ser5), .o_Tx_Done(done5), .o_Overflow(ovf5), .o_Fifo_Count(cnt5));

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t q8[$];
  frame_t q5[$];
  int n_checks = 0;
  int n_errors = 0;
  int ndone8 = 0;
  int novf8 = 0;
  bit chk_gap = 0;
  bit busy [2];

  always @(posedge clk) begin
    if (done8 === 1'b1) ndone8 <= ndone8 + 1;
    if (ovf8 === 1'b1) novf8 <= novf8 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input logic [8:0] d, input int nb, input logic [1:0] m,
                                input logic two);
    frame_t f;
    logic p;
    p = 1'b0;
    f.bits = '0;
    f.len = 1;
    for (int i = 0; i < nb; i++) begin
      f.bits[f.len] = d[i];
      p = p ^ d[i];
      f.len++;
    end
    if (m == 2'b01) begin f.bits[f.len] = p;  f.len++; end
    if (m == 2'b10) begin f.bits[f.len] = ~p; f.len++; end
    f.bits[f.len] = 1'b1;
    f.len++;
    if (two) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  function automatic logic ln(input bit s);  return s ? ser5 : ser8;       endfunction
  function automatic logic dn(input bit s);  return s ? done5 : done8;     endfunction
  function automatic logic ac(input bit s);  return s ? active5 : active8; endfunction

  task automatic monitor(input bit sel);
    frame_t f;
    int hi_run;
    bit prev, abort;
    hi_run = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0;
        hi_run = 0;
      end else if (ln(sel) === 1'b0) begin
        if ((sel ? q5.size() : q8.size()) == 0) begin
          chk(sel ? "m5_unexpected_start" : "m8_unexpected_start", 0, 1);
        end else begin
          f = sel ? q5.pop_front() : q8.pop_front();
          if (!sel && chk_gap && prev) chk("m8_gap", hi_run, 2);
          busy[sel] = 1;
          abort = 0;
          for (int j = 0; j < f.len; j++) begin
            for (int c = 0; c < CPB; c++) begin
              if (j != 0 || c != 0) @(negedge clk);
              if (!rst_n) begin abort = 1; break; end
              chk(sel ? "m5_line" : "m8_line", {31'b0, ln(sel)}, {31'b0, f.bits[j]});
              chk(sel ? "m5_done_mid" : "m8_done_mid", {31'b0, dn(sel)}, 0);
              chk(sel ? "m5_active" : "m8_active", {31'b0, ac(sel)}, 1);
            end
            if (abort) break;
          end
          if (!abort) begin
            @(negedge clk);
            if (rst_n) begin
              chk(sel ? "m5_done" : "m8_done", {31'b0, dn(sel)}, 1);
              chk(sel ? "m5_cleanup_line" : "m8_cleanup_line", {31'b0, ln(sel)}, 1);
              chk(sel ? "m5_cleanup_active" : "m8_cleanup_active", {31'b0, ac(sel)}, 0);
            end else abort = 1;
          end
          prev = !abort;
          hi_run = 1;
          busy[sel] = 0;
        end
      end else hi_run++;
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  task automatic write8(input logic [7:0] d);
    dv8 = 1'b1;
    b8 = d;
    q8.push_back(mk({1'b0, d}, 8, pm, ts));
    @(negedge clk);
    dv8 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((q8.size() != 0 || q5.size() != 0 || busy[0] || busy[1] || active8 || active5 ||
            cnt8 != 0 || cnt5 != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {31'b0, k < budget}, 1);
    @(negedge clk);
  endtask

  initial begin
    int d0, o0;
    logic [2:0] cnt_exp [6];
    cnt_exp = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    rst_n = 1'b0; pm = 2'b00; ts = 1'b0;
    dv8 = 1'b0; b8 = '0; dv5 = 1'b0; b5 = '0;
    repeat (3) @(negedge clk);
    chk("rst_line", {31'b0, ser8}, 1);
    chk("rst_active", {31'b0, active8}, 0);
    chk("rst_done", {31'b0, done8}, 0);
    chk("rst_ovf", {31'b0, ovf8}, 0);
    chk("rst_count", {29'b0, cnt8}, 0);
    chk("rst_ready", {31'b0, ready8}, 1);
    chk("rst_line5", {31'b0, ser5}, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5, latency and FIFO count
    d0 = ndone8;
    write8(8'hA5);
    chk("t1_count_acc", {29'b0, cnt8}, 1);
    chk("t1_line_still_high", {31'b0, ser8}, 1);
    @(negedge clk);
    chk("t1_line_fell", {31'b0, ser8}, 0);
    chk("t1_count_pop", {29'b0, cnt8}, 0);
    wait_idle(200);
    chk("t1_done_pulses", ndone8 - d0, 1);

    // Even then odd parity on 0x07
    pm = 2'b01;
    write8(8'h07);
    wait_idle(200);
    pm = 2'b10;
    write8(8'h07);
    wait_idle(200);
    pm = 2'b00;

    // Two stop bits, settings changed mid-frame
    d0 = ndone8;
    ts = 1'b1;
    write8(8'h5A);
    repeat (3) @(negedge clk);
    ts = 1'b0;
    pm = 2'b01;
    wait_idle(200);
    pm = 2'b00;
    chk("t3_done_pulses", ndone8 - d0, 1);

    // Burst of 6 writes into a 4-deep FIFO
    d0 = ndone8;
    o0 = novf8;
    for (int i = 0; i < 6; i++) begin
      dv8 = 1'b1;
      b8 = 8'h10 + 8'(i * 17);
      #1;
      chk("t4_ready", {31'b0, ready8}, (i != 5) ? 1 : 0);
      chk("t4_count", {29'b0, cnt8}, {29'b0, cnt_exp[i]});
      chk("t4_ovf", {31'b0, ovf8}, (i == 5) ? 1 : 0);
      if (i < 5) q8.push_back(mk({1'b0, b8}, 8, pm, ts));
      @(negedge clk);
    end
    dv8 = 1'b0;
    chk_gap = 1;
    wait_idle(800);
    chk_gap = 0;
    chk("t4_done_pulses", ndone8 - d0, 5);
    chk("t4_ovf_pulses", novf8 - o0, 1);

    // Reset during data bit 3
    write8(8'hFF);
    write8(8'hAA);
    repeat (16) @(negedge clk);
    d0 = ndone8;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_line_high", {31'b0, ser8}, 1);
    chk("t5_count", {29'b0, cnt8}, 0);
    chk("t5_active", {31'b0, active8}, 0);
    chk("t5_done", {31'b0, done8}, 0);
    repeat (2) @(negedge clk);
    chk("t5_done_in_rst", {31'b0, done8}, 0);
    q8.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_done", ndone8 - d0, 0);
    write8(8'h3C);
    wait_idle(200);
    chk("t5_done_after", ndone8 - d0, 1);

    // 5-bit instance
    dv5 = 1'b1;
    b5 = 5'h15;
    q5.push_back(mk({4'b0, 5'h15}, 5, pm, ts));
    @(negedge clk);
    dv5 = 1'b0;
    chk("t6_count", {29'b0, cnt5}, 1);
    wait_idle(200);
    chk("t6_line_idle", {31'b0, ser5}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
